// File: rtl/aluop_seq.sv
// aluop_seq: sequences an external combinational 8-bit ALU through opcodes 0..LAST_OP.
//   clk, rst_n       : rising-edge clock, async active-low reset (sync release upstream)
//   sw, btn, mode    : operand switches, raw push button, 1 = auto / 0 = manual step
//   alu_op/a/b       : registered opcode and operands driven to the ALU
//   alu_y            : combinational ALU result, sampled on each capture
//   leds, res_valid  : last captured result and its one-cycle update strobe
//   busy, done       : registered RUN / DONE state flags
module aluop_seq #(
  parameter int unsigned DWELL   = 50000000,
  parameter int unsigned LAST_OP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btn,
  input  logic       mode,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  output logic [7:0] leds,
  output logic       res_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned D_W   = 8;
  localparam int unsigned CNT_W = $clog2(DWELL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             btn_s1_q, btn_s2_q, btn_prev_q;
  logic             press_c;
  logic             step_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [D_W-1:0]   alu_a_q, alu_a_d;
  logic [D_W-1:0]   alu_b_q, alu_b_d;
  logic [D_W-1:0]   leds_q, leds_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Two-flop synchronizer plus rising-edge detect: one pulse per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign press_c = btn_s2_q & ~btn_prev_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      leds_q      <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      leds_q      <= leds_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    leds_d      = leds_q;
    res_valid_d = 1'b0;
    step_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (press_c) begin
          alu_a_d = sw;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (press_c) begin
          alu_b_d  = sw;
          alu_op_d = '0;
          cnt_d    = '0;
          mode_d   = mode;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Auto mode ignores the button; manual mode keeps the counter parked at 0.
        if (mode_q) begin
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            step_c = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d  = '0;
          step_c = press_c;
        end
        if (step_c) begin
          leds_d      = alu_y;
          res_valid_d = 1'b1;
          if (alu_op_q == OP_W'(LAST_OP)) begin
            state_d = S_DONE;
          end else begin
            alu_op_d = alu_op_q + OP_W'(1);
          end
        end
      end
      S_DONE: begin
        if (press_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign leds      = leds_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aluop_seq.sv
// Bench for aluop_seq: drives button/switch stimulus, models the external ALU,
// and compares every captured result against opcode-indexed expectations.
module tb_aluop_seq;

  localparam int unsigned DWELL   = 4;
  localparam int unsigned LAST_OP = 8;
  localparam int unsigned NCAP    = LAST_OP + 1;

  localparam logic [7:0] EXP1 [9] = '{8'h33, 8'h11, 8'h00, 8'h33, 8'h33, 8'hDD, 8'h22, 8'h23, 8'h21};
  localparam logic [7:0] EXP2 [9] = '{8'h00, 8'hFE, 8'h01, 8'hFF, 8'hFE, 8'h00, 8'hFF, 8'h00, 8'hFE};
  localparam logic [7:0] EXP3 [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h01, 8'hFF};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       btn = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y, leds;
  logic       res_valid, busy, done;

  int n_vec  = 0;
  int n_fail = 0;

  int         cyc = 0;
  int         run_t = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] cap_v [$];
  int         cap_t [$];

  aluop_seq #(.DWELL(DWELL), .LAST_OP(LAST_OP)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .mode(mode),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .leds(leds), .res_valid(res_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference ALU: add, sub, and, or, xor, not A, pass A, inc A, dec A.
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a;
      4'd7: return a + 8'd1;
      4'd8: return a - 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_y = alu_ref(alu_op, alu_a, alu_b);

  // Record each capture (value + cycle) and the cycle RUN was entered.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (res_valid) begin
      cap_v.push_back(leds);
      cap_t.push_back(cyc);
    end
    if (busy && !busy_prev) run_t = cyc;
    busy_prev = busy;
    if (alu_op > 4'(LAST_OP)) begin
      n_fail++;
      $display("FAIL op_range: alu_op=%0d exceeds %0d", alu_op, LAST_OP);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] cap_at(input int i);
    if (i < cap_v.size()) return cap_v[i];
    return 8'hxx;
  endfunction

  function automatic int gap_at(input int i);
    if (i >= cap_t.size()) return -1;
    if (i == 0) return cap_t[0] - run_t;
    return cap_t[i] - cap_t[i-1];
  endfunction

  task automatic press(input int hold);
    @(negedge clk);
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn = 1'b0; sw = 8'h00; mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cap_v.delete(); cap_t.delete();
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic m);
    sw = a;
    press(1);
    sw = b; mode = m;
    cap_v.delete(); cap_t.delete();
    press(1);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({alu_op, alu_a, alu_b, leds, res_valid, busy, done} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {alu_op, alu_a, alu_b, leds, res_valid, busy, done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, res_valid, leds} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h required 0", {busy, done, res_valid, leds});
    end
  endtask

  task automatic test_auto_run();
    bit ok;
    do_reset();
    sw = 8'h22;
    press(1);
    n_vec++;
    if (alu_a !== 8'h22 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_load_a: alu_a=%h busy=%b required 22/0", alu_a, busy);
    end
    sw = 8'h11; mode = 1'b1;
    cap_v.delete(); cap_t.delete();
    press(1);
    n_vec++;
    if (alu_b !== 8'h11 || busy !== 1'b1 || alu_op !== 4'd0) begin
      n_fail++;
      $display("FAIL auto_load_b: alu_b=%h busy=%b op=%0d required 11/1/0", alu_b, busy, alu_op);
    end
    wait_done(200, ok);
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL auto_done_timeout: done=%b required 1", done); end
    n_vec++;
    if (cap_v.size() != NCAP) begin
      n_fail++; $display("FAIL auto_pulses: got %0d required %0d", cap_v.size(), NCAP);
    end
    for (int i = 0; i < int'(NCAP); i++) begin
      n_vec++;
      if (cap_at(i) !== EXP1[i] || gap_at(i) != int'(DWELL)) begin
        n_fail++;
        $display("FAIL auto_cap%0d: leds=%h gap=%0d required %h gap %0d", i, cap_at(i), gap_at(i), EXP1[i], DWELL);
      end
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || leds !== 8'h21 || alu_op !== 4'd8 || cap_v.size() != NCAP) begin
      n_fail++;
      $display("FAIL auto_done_hold: done=%b busy=%b leds=%h op=%0d caps=%0d required 1/0/21/8/9",
               done, busy, leds, alu_op, cap_v.size());
    end
  endtask

  task automatic test_manual();
    do_reset();
    load(8'hFF, 8'h01, 1'b0);
    for (int i = 0; i < int'(NCAP); i++) begin
      repeat ($urandom_range(8, 40)) @(negedge clk);
      n_vec++;
      if (cap_v.size() != i) begin
        n_fail++; $display("FAIL manual_idle_gap%0d: caps=%0d required %0d", i, cap_v.size(), i);
      end
      press(1);
      n_vec++;
      if (cap_v.size() != i + 1 || cap_at(i) !== EXP2[i]) begin
        n_fail++;
        $display("FAIL manual_cap%0d: caps=%0d leds=%h required %0d/%h", i, cap_v.size(), cap_at(i), i + 1, EXP2[i]);
      end
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || leds !== 8'hFE) begin
      n_fail++; $display("FAIL manual_done: done=%b busy=%b leds=%h required 1/0/FE", done, busy, leds);
    end
  endtask

  task automatic test_held_button();
    do_reset();
    sw = 8'h5A;
    press(100);
    n_vec++;
    if (alu_a !== 8'h5A || busy !== 1'b0 || alu_b !== 8'h00 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_one_press: alu_a=%h busy=%b alu_b=%h required 5A/0/00", alu_a, busy, alu_b);
    end
    sw = 8'h3C; mode = 1'b1;
    press(1);
    n_vec++;
    if (busy !== 1'b1 || alu_b !== 8'h3C) begin
      n_fail++; $display("FAIL held_then_load_b: busy=%b alu_b=%h required 1/3C", busy, alu_b);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int ncap;
    logic [7:0] a, b;
    do_reset();
    a = 8'($urandom); b = 8'($urandom);
    load(a, b, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (alu_op == 4'd4) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok) begin n_fail++; $display("FAIL midrun_reach_op4: op=%0d required 4", alu_op); end
    ncap = cap_v.size();
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({alu_op, alu_a, alu_b, leds, res_valid, busy, done} !== 31'd0) begin
      n_fail++;
      $display("FAIL midrun_async_clear: got %h required 0", {alu_op, alu_a, alu_b, leds, res_valid, busy, done});
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cap_v.size() != ncap) begin
      n_fail++; $display("FAIL midrun_no_partial: caps=%0d required %0d", cap_v.size(), ncap);
    end
    sw = 8'h77; mode = 1'b1;
    press(1);
    n_vec++;
    if (alu_a !== 8'h77 || busy !== 1'b0 || alu_b !== 8'h00) begin
      n_fail++; $display("FAIL midrun_restart_load_a: alu_a=%h busy=%b alu_b=%h required 77/0/00", alu_a, busy, alu_b);
    end
    sw = 8'h12;
    cap_v.delete(); cap_t.delete();
    press(1);
    wait_done(200, ok);
    n_vec++;
    if (!ok || cap_v.size() != NCAP || cap_at(0) !== alu_ref(4'd0, 8'h77, 8'h12)) begin
      n_fail++; $display("FAIL midrun_rerun: done=%b caps=%0d first=%h required 1/9/%h",
                         done, cap_v.size(), cap_at(0), alu_ref(4'd0, 8'h77, 8'h12));
    end
  endtask

  task automatic test_press_spam();
    do_reset();
    load(8'h22, 8'h11, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
      btn = (cap_v.size() >= int'(LAST_OP)) ? 1'b0 : ~btn;
      if (cap_v.size() >= 1) mode = ~mode;
      sw = 8'($urandom);
    end
    btn = 1'b0;
    n_vec++;
    if (done !== 1'b1 || cap_v.size() != NCAP) begin
      n_fail++; $display("FAIL spam_done: done=%b caps=%0d required 1/9", done, cap_v.size());
    end
    for (int i = 0; i < int'(NCAP); i++) begin
      n_vec++;
      if (cap_at(i) !== EXP1[i] || gap_at(i) != int'(DWELL)) begin
        n_fail++;
        $display("FAIL spam_cap%0d: leds=%h gap=%0d required %h gap %0d", i, cap_at(i), gap_at(i), EXP1[i], DWELL);
      end
    end
    n_vec++;
    if (alu_a !== 8'h22 || alu_b !== 8'h11) begin
      n_fail++; $display("FAIL spam_operands: a=%h b=%h required 22/11", alu_a, alu_b);
    end
  endtask

  task automatic test_done_to_idle();
    bit ok;
    repeat (3) @(negedge clk);
    press(1);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || leds !== 8'h21 || alu_op !== 4'd8) begin
      n_fail++; $display("FAIL done_to_idle: done=%b busy=%b leds=%h op=%0d required 0/0/21/8", done, busy, leds, alu_op);
    end
    load(8'h00, 8'h00, 1'b1);
    wait_done(200, ok);
    n_vec++;
    if (!ok || cap_v.size() != NCAP) begin
      n_fail++; $display("FAIL rerun_done: done=%b caps=%0d required 1/9", done, cap_v.size());
    end
    for (int i = 0; i < int'(NCAP); i++) begin
      n_vec++;
      if (cap_at(i) !== EXP3[i]) begin
        n_fail++; $display("FAIL rerun_cap%0d: leds=%h required %h", i, cap_at(i), EXP3[i]);
      end
    end
  endtask

  task automatic test_random_runs();
    bit ok;
    logic [7:0] a, b;
    logic m;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
      load(a, b, m);
      if (m) begin
        wait_done(200, ok);
      end else begin
        for (int i = 0; i < int'(NCAP); i++) begin
          repeat ($urandom_range(2, 12)) @(negedge clk);
          press(1);
        end
        ok = done;
      end
      n_vec++;
      if (!ok || cap_v.size() != NCAP) begin
        n_fail++; $display("FAIL rand%0d_done: done=%b caps=%0d required 1/9", r, done, cap_v.size());
      end
      for (int i = 0; i < int'(NCAP); i++) begin
        n_vec++;
        if (cap_at(i) !== alu_ref(4'(i), a, b)) begin
          n_fail++;
          $display("FAIL rand%0d_cap%0d: a=%h b=%h mode=%b leds=%h required %h",
                   r, i, a, b, m, cap_at(i), alu_ref(4'(i), a, b));
        end
      end
      press(1);
    end
  endtask

  initial begin
    test_reset();
    test_auto_run();
    test_manual();
    test_held_button();
    test_reset_mid_run();
    test_press_spam();
    test_done_to_idle();
    test_random_runs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
